spi_master: RTL and testbench

- SPI master word engine with an internal transmit queue (TQueue) and receive queue (RQueue).
- Words are accepted from a push-style producer, queued, and shifted out full-duplex, MSB first.
- Each word captured from MISO is queued and offered to a push-style consumer.
- Sits behind the system's SPI transmitter wrapper. A separate generator supplies a slow toggling bit-clock level (spi_clk), which this block samples in the clk domain.

---
 rtl/spi_master.sv | 207 ++++++++++++++++++++
 tb/tb_spi_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : SPI mode-0 master word engine. Words from a push-style producer
//            are queued in TQueue, shifted out MSB first while MISO is
//            captured, and the captured words are queued in RQueue for a
//            push-style consumer. The bit rate comes from an external slow
//            toggling level (spi_clk) that is edge-detected in the clk domain.
// Ports    : clk, rst        - system clock, async active-high reset
//            spi_clk         - slow bit-clock level from the generator
//            t_data/t_request/t_done      - producer handshake
//            r_data/r_request/r_done      - consumer handshake
//            overflow_tq/overflow_rq      - sticky drop flags
//            miso/mosi/n_cs/sck           - SPI pins (mode 0)
// Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int DATA_WIDTH = 16,
    parameter int TQ_DEPTH   = 8,
    parameter int RQ_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_clk,
    input  logic [DATA_WIDTH-1:0] t_data,
    input  logic                  t_request,
    output logic                  t_done,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_request,
    input  logic                  r_done,
    output logic                  overflow_tq,
    output logic                  overflow_rq,
    input  logic                  miso,
    output logic                  mosi,
    output logic                  n_cs,
    output logic                  sck
);

    localparam int c_TQ_AW  = $clog2(TQ_DEPTH);
    localparam int c_RQ_AW  = $clog2(RQ_DEPTH);
    localparam int c_CNT_W  = $clog2(DATA_WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_BITS = c_CNT_W'(DATA_WIDTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_GAP   = 2'd2;

    logic [1:0]            r_state;
    logic                  r_spiClkD;
    logic                  r_tDone;
    logic                  r_ovfTq;
    logic                  r_ovfRq;
    logic                  r_mosi;
    logic                  r_nCs;
    logic                  r_sck;
    logic [c_CNT_W-1:0]    r_bitCnt;
    logic [DATA_WIDTH-1:0] r_txShift;
    logic [DATA_WIDTH-1:0] r_rxShift;

    // Queues: pointers carry one extra bit so full and empty are distinct.
    logic [DATA_WIDTH-1:0] r_tqMem [TQ_DEPTH];
    logic [DATA_WIDTH-1:0] r_rqMem [RQ_DEPTH];
    logic [c_TQ_AW:0]      r_tqWr;
    logic [c_TQ_AW:0]      r_tqRd;
    logic [c_RQ_AW:0]      r_rqWr;
    logic [c_RQ_AW:0]      r_rqRd;

    logic                  w_rise;
    logic                  w_fall;
    logic                  w_tqEmpty;
    logic                  w_tqFull;
    logic                  w_rqEmpty;
    logic                  w_rqFull;
    logic                  w_tAccept;
    logic                  w_tqPush;
    logic                  w_tqPop;
    logic                  w_frameEnd;
    logic                  w_rqPush;
    logic                  w_rqPop;
    logic [DATA_WIDTH-1:0] w_tqHead;

    assign w_rise = spi_clk & ~r_spiClkD;
    assign w_fall = ~spi_clk & r_spiClkD;

    assign w_tqEmpty = (r_tqWr == r_tqRd);
    assign w_tqFull  = (r_tqWr[c_TQ_AW] != r_tqRd[c_TQ_AW]) &&
                       (r_tqWr[c_TQ_AW-1:0] == r_tqRd[c_TQ_AW-1:0]);
    assign w_rqEmpty = (r_rqWr == r_rqRd);
    assign w_rqFull  = (r_rqWr[c_RQ_AW] != r_rqRd[c_RQ_AW]) &&
                       (r_rqWr[c_RQ_AW-1:0] == r_rqRd[c_RQ_AW-1:0]);

    // A request is ignored in the cycle t_done is high, so a held request
    // is taken once per two cycles at most.
    assign w_tAccept  = t_request & ~r_tDone;
    assign w_tqPush   = w_tAccept & ~w_tqFull;
    assign w_tqPop    = (r_state == c_IDLE) & w_fall & ~w_tqEmpty;
    assign w_frameEnd = (r_state == c_SHIFT) & w_fall & (r_bitCnt == c_BITS);
    assign w_rqPush   = w_frameEnd & ~w_rqFull;
    assign w_rqPop    = r_done & ~w_rqEmpty;
    assign w_tqHead   = r_tqMem[r_tqRd[c_TQ_AW-1:0]];

    assign t_done      = r_tDone;
    assign r_request   = ~w_rqEmpty;
    // Gate the head so r_data reads zero whenever nothing is queued.
    assign r_data      = w_rqEmpty ? '0 : r_rqMem[r_rqRd[c_RQ_AW-1:0]];
    assign overflow_tq = r_ovfTq;
    assign overflow_rq = r_ovfRq;
    assign mosi        = r_mosi;
    assign n_cs        = r_nCs;
    assign sck         = r_sck;

    // Queue storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_tqPush) begin
            r_tqMem[r_tqWr[c_TQ_AW-1:0]] <= t_data;
        end
        if (w_rqPush) begin
            r_rqMem[r_rqWr[c_RQ_AW-1:0]] <= r_rxShift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_spiClkD <= 1'b0;
            r_tDone   <= 1'b0;
            r_ovfTq   <= 1'b0;
            r_ovfRq   <= 1'b0;
            r_mosi    <= 1'b0;
            r_nCs     <= 1'b1;
            r_sck     <= 1'b0;
            r_bitCnt  <= '0;
            r_txShift <= '0;
            r_rxShift <= '0;
            r_tqWr    <= '0;
            r_tqRd    <= '0;
            r_rqWr    <= '0;
            r_rqRd    <= '0;
        end else begin
            r_spiClkD <= spi_clk;
            r_tDone   <= w_tAccept;

            if (w_tqPush) begin
                r_tqWr <= r_tqWr + 1'b1;
            end
            if (w_tAccept && w_tqFull) begin
                r_ovfTq <= 1'b1;
            end
            if (w_tqPop) begin
                r_tqRd <= r_tqRd + 1'b1;
            end
            if (w_rqPush) begin
                r_rqWr <= r_rqWr + 1'b1;
            end
            if (w_frameEnd && w_rqFull) begin
                r_ovfRq <= 1'b1;
            end
            if (w_rqPop) begin
                r_rqRd <= r_rqRd + 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    r_sck <= 1'b0;
                    if (w_tqPop) begin
                        r_txShift <= w_tqHead;
                        r_mosi    <= w_tqHead[DATA_WIDTH-1];
                        r_nCs     <= 1'b0;
                        r_bitCnt  <= '0;
                        r_rxShift <= '0;
                        r_state   <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    // sck trails spi_clk by the edge-detect delay, so mosi
                    // (updated on fall) is settled well before each sck rise.
                    r_sck <= r_spiClkD;
                    if (w_rise) begin
                        r_rxShift <= {r_rxShift[DATA_WIDTH-2:0], miso};
                        r_bitCnt  <= r_bitCnt + 1'b1;
                    end else if (w_fall) begin
                        if (r_bitCnt == c_BITS) begin
                            r_nCs   <= 1'b1;
                            r_sck   <= 1'b0;
                            r_state <= c_GAP;
                        end else begin
                            r_txShift <= r_txShift << 1;
                            r_mosi    <= r_txShift[DATA_WIDTH-2];
                        end
                    end
                end
                c_GAP: begin
                    // Holds n_cs high for a full spi_clk period between words.
                    r_sck <= 1'b0;
                    if (w_fall) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Purpose  : Self-checking bench for spi_master. Table-driven single-word
//            frames plus directed sequences for queue overflow and reset
//            during a frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        spiClk = 1'b0;
    logic        spiRun = 1'b1;
    logic [15:0] tData = '0;
    logic        tRequest = 1'b0;
    logic        tDone;
    logic [15:0] rData;
    logic        rRequest;
    logic        rDone = 1'b0;
    logic        ovfTq;
    logic        ovfRq;
    logic        miso;
    logic        mosi;
    logic        nCs;
    logic        sck;
    int          misoMode = 0;   // 0 loopback, 1 tied high, 2 tied low

    int checks = 0;
    int errors = 0;

    assign miso = (misoMode == 0) ? mosi : (misoMode == 1);

    spi_master #(
        .DATA_WIDTH(16),
        .TQ_DEPTH  (8),
        .RQ_DEPTH  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_clk    (spiClk),
        .t_data     (tData),
        .t_request  (tRequest),
        .t_done     (tDone),
        .r_data     (rData),
        .r_request  (rRequest),
        .r_done     (rDone),
        .overflow_tq(ovfTq),
        .overflow_rq(ovfRq),
        .miso       (miso),
        .mosi       (mosi),
        .n_cs       (nCs),
        .sck        (sck)
    );

    always #5 clk = ~clk;

    // Slow bit clock: toggles every 4 clk cycles while enabled.
    initial begin
        forever begin
            repeat (4) @(negedge clk);
            if (spiRun) spiClk = ~spiClk;
        end
    end

    // Frame monitor: mosi captured on each sck rise, logged when n_cs rises.
    logic        sckPrev = 1'b0;
    logic        nCsPrev = 1'b1;
    logic [15:0] capBits = '0;
    int          capCnt = 0;
    logic [15:0] txLog[$];
    int          cntLog[$];

    always @(negedge clk) begin
        if (sck && !sckPrev) begin
            capBits = {capBits[14:0], mosi};
            capCnt++;
        end
        if (nCs && !nCsPrev) begin
            txLog.push_back(capBits);
            cntLog.push_back(capCnt);
            capBits = '0;
            capCnt  = 0;
        end
        sckPrev = sck;
        nCsPrev = nCs;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        int n;
        n = 0;
        @(negedge clk);
        tData    = w;
        tRequest = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!tDone && n < 20);
        chk("t_done_seen", tDone, 1'b1);
        tRequest = 1'b0;
        @(negedge clk);
        chk("t_done_one_cycle", tDone, 1'b0);
    endtask

    task automatic waitLog(input int n, input int budget);
        int k;
        k = 0;
        while (txLog.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("frame_count", txLog.size(), n);
    endtask

    task automatic pop(input logic [15:0] exp);
        int k;
        k = 0;
        while (!rRequest && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("r_request_high", rRequest, 1'b1);
        chk("r_data", rData, exp);
        rDone = 1'b1;
        @(negedge clk);
        rDone = 1'b0;
    endtask

    typedef struct {
        logic [15:0] tx;
        int          mode;
        logic [15:0] expRx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{tx: 16'hA5C3, mode: 0, expRx: 16'hA5C3};
        vecs[1] = '{tx: 16'h0000, mode: 1, expRx: 16'hFFFF};
        vecs[2] = '{tx: 16'hFFFF, mode: 2, expRx: 16'h0000};
        vecs[3] = '{tx: 16'h8001, mode: 0, expRx: 16'h8001};
        vecs[4] = '{tx: 16'h3C5A, mode: 1, expRx: 16'hFFFF};

        // Reset with spi_clk running.
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_n_cs", nCs, 1'b1);
        chk("rst_sck", sck, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_r_request", rRequest, 1'b0);
        chk("rst_r_data", rData, 16'h0000);
        chk("rst_t_done", tDone, 1'b0);
        chk("rst_ovf_tq", ovfTq, 1'b0);
        chk("rst_ovf_rq", ovfRq, 1'b0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_n_cs", nCs, 1'b1);
        txLog.delete();
        cntLog.delete();

        // Single-word frames.
        for (int i = 0; i < 5; i++) begin
            misoMode = vecs[i].mode;
            txLog.delete();
            cntLog.delete();
            push(vecs[i].tx);
            waitLog(1, 600);
            if (txLog.size() >= 1) begin
                chk("mosi_bits", txLog[0], vecs[i].tx);
                chk("sck_pulses", cntLog[0], 16);
            end
            pop(vecs[i].expRx);
            chk("r_request_after_pop", rRequest, 1'b0);
            chk("ovf_tq_clear", ovfTq, 1'b0);
            chk("ovf_rq_clear", ovfRq, 1'b0);
        end

        // TQueue overflow with spi_clk frozen.
        spiRun = 1'b0;
        misoMode = 0;
        repeat (20) @(negedge clk);
        txLog.delete();
        cntLog.delete();
        for (int i = 1; i <= 9; i++) begin
            push(16'(i));
            if (i == 8) chk("ovf_tq_at_full", ovfTq, 1'b0);
        end
        chk("ovf_tq_set", ovfTq, 1'b1);
        spiRun = 1'b1;
        waitLog(8, 3000);
        repeat (400) @(negedge clk);
        chk("tq_frames_total", txLog.size(), 8);
        for (int i = 0; i < 8 && i < txLog.size(); i++) begin
            chk("tq_word_order", txLog[i], 16'(i + 1));
        end
        chk("ovf_rq_8_deep", ovfRq, 1'b0);
        for (int i = 1; i <= 8; i++) pop(16'(i));
        chk("rq_empty_after_8", rRequest, 1'b0);
        chk("ovf_tq_sticky", ovfTq, 1'b1);

        // RQueue overflow: loopback, no pops.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ovf_tq_cleared", ovfTq, 1'b0);
        repeat (10) @(negedge clk);
        txLog.delete();
        cntLog.delete();
        for (int i = 0; i < 9; i++) begin
            push(16'h0011 + 16'(i));
            waitLog(i + 1, 600);
            if (i == 7) chk("ovf_rq_at_full", ovfRq, 1'b0);
        end
        chk("ovf_rq_set", ovfRq, 1'b1);
        for (int i = 0; i < 8; i++) pop(16'h0011 + 16'(i));
        chk("rq_empty_after_drain", rRequest, 1'b0);

        // Reset in the middle of a frame.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        misoMode = 0;
        push(16'h1234);
        begin
            int k;
            k = 0;
            while (capCnt < 5 && k < 600) begin
                @(negedge clk);
                k++;
            end
            chk("mid_sck_pulses", capCnt, 5);
        end
        chk("mid_n_cs_low", nCs, 1'b0);
        rst = 1'b1;
        #1;
        chk("abort_n_cs", nCs, 1'b1);
        chk("abort_sck", sck, 1'b0);
        chk("abort_r_request", rRequest, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        txLog.delete();
        cntLog.delete();
        repeat (300) @(negedge clk);
        chk("abort_no_rx", rRequest, 1'b0);
        chk("abort_no_frame", txLog.size(), 0);
        push(16'h5A5A);
        waitLog(1, 600);
        if (txLog.size() >= 1) begin
            chk("post_abort_bits", txLog[0], 16'h5A5A);
            chk("post_abort_pulses", cntLog[0], 16);
        end
        pop(16'h5A5A);
        chk("post_abort_empty", rRequest, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
